trap_controller: RTL and testbench

TRAP_CONTROLLER -- requirements
Module: trap_controller

---
 rtl/trap_controller_pkg.sv | 15 +
 rtl/trap_controller_if.sv | 26 ++
 rtl/trap_controller_prio.sv | 25 ++
 rtl/trap_controller.sv | 112 +++++++++++
 tb/tb_trap_controller.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/trap_controller_pkg.sv
// Shared types and constants for the trap controller.
package trap_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ENTER,
        HANDLER,
        FATAL
    } state_e;

    localparam logic [31:0] CAUSE_ILLEGAL     = 32'h0000_0002;
    localparam logic [31:0] IRQ_CAUSE_BASE    = 32'h8000_0010;
    localparam int          DEFAULT_MAX_DEPTH = 3;

endpackage

// File: rtl/trap_controller_if.sv
// Decoder/CSR-side requests in, trap/return controls out.
interface trap_controller_if #(
    parameter int IRQ_NUM = 16
);
    logic               illegal_instr_i;
    logic               mret_i;
    logic               stall_i;
    logic [IRQ_NUM-1:0] irq_req_i;
    logic [IRQ_NUM-1:0] mie_i;
    logic               trap_o;
    logic [31:0]        mcause_o;
    logic [IRQ_NUM-1:0] irq_ack_o;
    logic               irq_ret_o;
    logic               in_handler_o;
    logic               fatal_o;

    modport slave (
        input  illegal_instr_i, mret_i, stall_i, irq_req_i, mie_i,
        output trap_o, mcause_o, irq_ack_o, irq_ret_o, in_handler_o, fatal_o
    );

    modport master (
        output illegal_instr_i, mret_i, stall_i, irq_req_i, mie_i,
        input  trap_o, mcause_o, irq_ack_o, irq_ret_o, in_handler_o, fatal_o
    );
endinterface

// File: rtl/trap_controller_prio.sv
// Lowest-index-wins selector over the masked interrupt vector.
module irq_priority_encoder #(
    parameter int N   = 16,
    parameter int IDW = 4
) (
    input  logic [N-1:0]   req_i,
    output logic           valid_o,
    output logic [IDW-1:0] id_o,
    output logic [N-1:0]   onehot_o
);
    // Scan downward so the last hit, the lowest index, wins.
    always_comb begin
        valid_o  = 1'b0;
        id_o     = '0;
        onehot_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                valid_o     = 1'b1;
                id_o        = IDW'(i);
                onehot_o    = '0;
                onehot_o[i] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/trap_controller.sv
// Trap/interrupt entry FSM with bounded nesting depth and sticky overflow.
module trap_controller
    import trap_pkg::*;
#(
    parameter int IRQ_NUM   = 16,
    parameter int MAX_DEPTH = DEFAULT_MAX_DEPTH
) (
    input  logic              clk_i,
    input  logic              rst_i,
    trap_controller_if.slave  bus
);
    localparam int DW  = $clog2(MAX_DEPTH + 1);
    localparam int IDW = (IRQ_NUM > 1) ? $clog2(IRQ_NUM) : 1;

    state_e             state_q, state_d;
    logic [DW-1:0]      depth_q, depth_d;
    logic               trap_q, trap_d;
    logic [31:0]        mcause_q, mcause_d;
    logic [IRQ_NUM-1:0] ack_q, ack_d;
    logic               ret_q, ret_d;
    logic               fatal_q, fatal_d;
    logic               in_handler_q;

    logic               pe_valid;
    logic [IDW-1:0]     pe_id;
    logic [IRQ_NUM-1:0] pe_onehot;

    irq_priority_encoder #(.N(IRQ_NUM), .IDW(IDW)) u_prio (
        .req_i    (bus.irq_req_i & bus.mie_i),
        .valid_o  (pe_valid),
        .id_o     (pe_id),
        .onehot_o (pe_onehot)
    );

    always_comb begin
        state_d  = state_q;
        depth_d  = depth_q;
        trap_d   = 1'b0;
        mcause_d = mcause_q;
        ack_d    = '0;
        ret_d    = 1'b0;
        fatal_d  = fatal_q;
        case (state_q)
            IDLE: if (!bus.stall_i) begin
                if (bus.illegal_instr_i) begin
                    state_d  = ENTER;
                    trap_d   = 1'b1;
                    mcause_d = CAUSE_ILLEGAL;
                    depth_d  = depth_q + DW'(1);
                end else if (pe_valid) begin
                    state_d  = ENTER;
                    trap_d   = 1'b1;
                    mcause_d = IRQ_CAUSE_BASE + 32'(pe_id);
                    ack_d    = pe_onehot;
                    depth_d  = depth_q + DW'(1);
                end else if (bus.mret_i) begin
                    ret_d = 1'b1;
                end
            end
            ENTER: state_d = HANDLER;
            // Interrupts are deliberately not looked at here: no interrupt nesting.
            HANDLER: if (!bus.stall_i) begin
                if (bus.illegal_instr_i) begin
                    if (depth_q < DW'(MAX_DEPTH)) begin
                        state_d  = ENTER;
                        trap_d   = 1'b1;
                        mcause_d = CAUSE_ILLEGAL;
                        depth_d  = depth_q + DW'(1);
                    end else begin
                        state_d = FATAL;
                        fatal_d = 1'b1;
                    end
                end else if (bus.mret_i) begin
                    ret_d   = 1'b1;
                    depth_d = (depth_q != '0) ? depth_q - DW'(1) : '0;
                    if (depth_q <= DW'(1)) state_d = IDLE;
                end
            end
            FATAL: ;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            depth_q      <= '0;
            trap_q       <= 1'b0;
            mcause_q     <= '0;
            ack_q        <= '0;
            ret_q        <= 1'b0;
            fatal_q      <= 1'b0;
            in_handler_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            depth_q      <= depth_d;
            trap_q       <= trap_d;
            mcause_q     <= mcause_d;
            ack_q        <= ack_d;
            ret_q        <= ret_d;
            fatal_q      <= fatal_d;
            in_handler_q <= (depth_d != '0);
        end
    end

    assign bus.trap_o       = trap_q;
    assign bus.mcause_o     = mcause_q;
    assign bus.irq_ack_o    = ack_q;
    assign bus.irq_ret_o    = ret_q;
    assign bus.in_handler_o = in_handler_q;
    assign bus.fatal_o      = fatal_q;
endmodule

// File: tb/tb_trap_controller.sv
// Directed checks of trap entry, return, nesting overflow and reset.
module tb_trap_controller;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    trap_controller_if #(.IRQ_NUM(16)) bus ();

    trap_controller #(.IRQ_NUM(16), .MAX_DEPTH(3)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Advance one cycle; inputs and samples both sit 1 time unit past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        bus.illegal_instr_i = 1'b0;
        bus.mret_i          = 1'b0;
        bus.stall_i         = 1'b0;
        bus.irq_req_i       = '0;
        bus.mie_i           = 16'hFFFF;
    endtask

    // One mret from HANDLER depth 1 back to IDLE.
    task automatic leave();
        bus.mret_i = 1'b1;
        tick();
        bus.mret_i = 1'b0;
        tick();
    endtask

    int traps;

    initial begin
        idle_in();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk("rst_trap", 32'(bus.trap_o), 0);
        chk("rst_mcause", bus.mcause_o, 0);
        chk("rst_ack", 32'(bus.irq_ack_o), 0);
        chk("rst_ret", 32'(bus.irq_ret_o), 0);
        chk("rst_inh", 32'(bus.in_handler_o), 0);
        chk("rst_fatal", 32'(bus.fatal_o), 0);

        // Lowest enabled line of 0x0028 is 3.
        bus.irq_req_i = 16'h0028;
        tick();
        chk("irq_trap", 32'(bus.trap_o), 1);
        chk("irq_mcause", bus.mcause_o, 32'h8000_0013);
        chk("irq_ack", 32'(bus.irq_ack_o), 32'h0008);
        chk("irq_inh", 32'(bus.in_handler_o), 1);
        bus.irq_req_i = '0;
        tick();
        chk("enter_1cyc", 32'(bus.trap_o), 0);
        chk("hold_mcause", bus.mcause_o, 32'h8000_0013);
        bus.mret_i = 1'b1;
        tick();
        bus.mret_i = 1'b0;
        chk("mret_ret", 32'(bus.irq_ret_o), 1);
        chk("mret_inh", 32'(bus.in_handler_o), 0);
        tick();
        chk("ret_pulse", 32'(bus.irq_ret_o), 0);

        // Stalled illegal instruction accepted only after stall drops.
        bus.illegal_instr_i = 1'b1;
        bus.stall_i = 1'b1;
        traps = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            traps += int'(bus.trap_o);
        end
        chk("stall_notrap", traps, 0);
        bus.stall_i = 1'b0;
        tick();
        bus.illegal_instr_i = 1'b0;
        chk("stall_trap", 32'(bus.trap_o), 1);
        chk("stall_mcause", bus.mcause_o, 32'h2);
        chk("stall_ack", 32'(bus.irq_ack_o), 0);
        tick();
        chk("stall_once", 32'(bus.trap_o), 0);
        leave();

        // Interrupt held off in HANDLER, taken right after return.
        bus.illegal_instr_i = 1'b1;
        tick();
        bus.illegal_instr_i = 1'b0;
        bus.irq_req_i = 16'h0001;
        traps = 0;
        tick(); traps += int'(bus.trap_o);
        tick(); traps += int'(bus.trap_o);
        chk("hnd_nonest", traps, 0);
        bus.mret_i = 1'b1;
        tick();
        bus.mret_i = 1'b0;
        chk("hnd_ret", 32'(bus.irq_ret_o), 1);
        chk("hnd_ret_trap", 32'(bus.trap_o), 0);
        chk("hnd_ret_inh", 32'(bus.in_handler_o), 0);
        tick();
        chk("pend_trap", 32'(bus.trap_o), 1);
        chk("pend_mcause", bus.mcause_o, 32'h8000_0010);
        chk("pend_ack", 32'(bus.irq_ack_o), 32'h0001);
        bus.irq_req_i = '0;
        tick();
        leave();

        // Exception beats a simultaneous interrupt; interrupt stays pending.
        bus.illegal_instr_i = 1'b1;
        bus.irq_req_i = 16'h0002;
        tick();
        bus.illegal_instr_i = 1'b0;
        chk("mix_mcause", bus.mcause_o, 32'h2);
        chk("mix_ack", 32'(bus.irq_ack_o), 0);
        tick();
        bus.mret_i = 1'b1;
        tick();
        bus.mret_i = 1'b0;
        tick();
        chk("mix_irq_trap", 32'(bus.trap_o), 1);
        chk("mix_irq_mcause", bus.mcause_o, 32'h8000_0011);
        chk("mix_irq_ack", 32'(bus.irq_ack_o), 32'h0002);
        bus.irq_req_i = '0;
        tick();
        leave();

        // Masking: line 2 disabled, line 3 taken.
        bus.irq_req_i = 16'h0004;
        bus.mie_i = 16'h0000;
        tick();
        chk("mask_none", 32'(bus.trap_o), 0);
        bus.irq_req_i = 16'h000C;
        bus.mie_i = 16'hFFFB;
        tick();
        chk("mask_mcause", bus.mcause_o, 32'h8000_0013);
        chk("mask_ack", 32'(bus.irq_ack_o), 32'h0008);
        idle_in();
        tick();
        leave();

        // illegal+mret is illegal only; bare mret in IDLE saturates.
        bus.illegal_instr_i = 1'b1;
        bus.mret_i = 1'b1;
        tick();
        idle_in();
        chk("both_trap", 32'(bus.trap_o), 1);
        chk("both_ret", 32'(bus.irq_ret_o), 0);
        tick();
        leave();
        bus.mret_i = 1'b1;
        tick();
        bus.mret_i = 1'b0;
        chk("idle_mret_ret", 32'(bus.irq_ret_o), 1);
        chk("idle_mret_inh", 32'(bus.in_handler_o), 0);
        bus.illegal_instr_i = 1'b1;
        tick();
        bus.illegal_instr_i = 1'b0;
        chk("sat_trap", 32'(bus.trap_o), 1);
        tick();
        bus.mret_i = 1'b1;
        tick();
        bus.mret_i = 1'b0;
        chk("sat_inh", 32'(bus.in_handler_o), 0);
        tick();

        // Nesting overflow: three traps then sticky fatal.
        bus.illegal_instr_i = 1'b1;
        traps = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            traps += int'(bus.trap_o);
        end
        bus.illegal_instr_i = 1'b0;
        chk("nest_traps", traps, 3);
        chk("nest_fatal", 32'(bus.fatal_o), 1);
        bus.mret_i = 1'b1;
        tick();
        bus.mret_i = 1'b0;
        chk("fatal_noret", 32'(bus.irq_ret_o), 0);
        chk("fatal_sticky", 32'(bus.fatal_o), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("fatal_rst", 32'(bus.fatal_o), 0);
        chk("fatal_rst_inh", 32'(bus.in_handler_o), 0);

        // Reset while in ENTER.
        bus.illegal_instr_i = 1'b1;
        tick();
        chk("pre_rst_trap", 32'(bus.trap_o), 1);
        bus.illegal_instr_i = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("ent_rst_trap", 32'(bus.trap_o), 0);
        chk("ent_rst_mcause", bus.mcause_o, 0);
        chk("ent_rst_inh", 32'(bus.in_handler_o), 0);
        tick();
        chk("ent_rst_idle", 32'(bus.trap_o), 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
